// File: rtl/onchip_mem_arbiter.sv
// Arbiter that shares one single-port 32-bit on-chip RAM between two Avalon-MM requesters.
// m0 is the A-line acquisition writer and m1 is the host data path.
//
// Ports:
//   clk, reset_n            clock and asynchronous active-low reset
//   mK_* (K = 0, 1)         Avalon-MM slave side: address, byteenable, read, write, writedata
//                           in; waitrequest, readdata, readdatavalid, proto_err out
//   mem_*                   RAM side: address, byteenable, chipselect, write, writedata,
//                           clken out; readdata in (valid the cycle after a read command)
//
// Arbitration is round-robin with a bounded hold: the current owner keeps the RAM for up to
// MAX_HOLD consecutive grants while the other master is waiting. Commands to addresses at or
// above NUM_WORDS are accepted, but they never reach the RAM, and their reads return zero.
module onchip_mem_arbiter #(
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BE_W      = 4,
  parameter int unsigned NUM_WORDS = 256000,
  parameter int unsigned MAX_HOLD  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  output logic              m0_proto_err,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic              m1_proto_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  typedef enum logic [1:0] {OwnNone, OwnM0, OwnM1} owner_e;

  localparam logic [7:0]      MaxHold  = 8'(MAX_HOLD);
  localparam logic [ADDR_W:0] NumWords = (ADDR_W + 1)'(NUM_WORDS);

  owner_e     owner_q, owner_d;
  logic       last_q, last_d;  // 0: m0 was granted last, 1: m1
  logic [7:0] hold_q, hold_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_id_q, rd_id_d;
  logic       rd_oor_q, rd_oor_d;

  logic req0, req1, gnt0, gnt1, any_gnt;
  logic in_range0, in_range1, sel_in_range, sel_write, sel_read;

  assign req0      = m0_read | m0_write;
  assign req1      = m1_read | m1_write;
  assign in_range0 = {1'b0, m0_address} < NumWords;
  assign in_range1 = {1'b0, m1_address} < NumWords;

  // Grant decision; nothing is granted while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n) begin
      if (req0 && !req1) begin
        gnt0 = 1'b1;
      end else if (req1 && !req0) begin
        gnt1 = 1'b1;
      end else if (req0 && req1) begin
        if (owner_q == OwnM0 && hold_q < MaxHold) begin
          gnt0 = 1'b1;
        end else if (owner_q == OwnM1 && hold_q < MaxHold) begin
          gnt1 = 1'b1;
        end else if (last_q) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end
    end
  end

  assign any_gnt      = gnt0 | gnt1;
  assign sel_in_range = gnt1 ? in_range1 : in_range0;
  assign sel_write    = gnt1 ? m1_write : m0_write;
  // A combined read+write is executed as a write only.
  assign sel_read     = (gnt1 ? m1_read : m0_read) & ~sel_write;

  assign mem_address    = gnt1 ? m1_address : m0_address;
  assign mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = gnt1 ? m1_writedata : m0_writedata;
  assign mem_chipselect = any_gnt & sel_in_range;
  assign mem_write      = any_gnt & sel_in_range & sel_write;
  assign mem_clken      = reset_n;

  // Idle masters see waitrequest low; everything stalls while in reset.
  assign m0_waitrequest = ~reset_n | (req0 & ~gnt0);
  assign m1_waitrequest = ~reset_n | (req1 & ~gnt1);
  assign m0_proto_err   = gnt0 & m0_read & m0_write;
  assign m1_proto_err   = gnt1 & m1_read & m1_write;

  // Read data is steered to the issuer; out-of-range reads return zero.
  assign m0_readdatavalid = rd_pend_q & ~rd_id_q;
  assign m1_readdatavalid = rd_pend_q & rd_id_q;
  assign m0_readdata      = (m0_readdatavalid && !rd_oor_q) ? mem_readdata : '0;
  assign m1_readdata      = (m1_readdatavalid && !rd_oor_q) ? mem_readdata : '0;

  always_comb begin
    owner_d   = owner_q;
    last_d    = last_q;
    hold_d    = hold_q;
    rd_pend_d = any_gnt & sel_read;
    rd_id_d   = gnt1;
    rd_oor_d  = ~sel_in_range;
    if (any_gnt) begin
      owner_d = gnt1 ? OwnM1 : OwnM0;
      last_d  = gnt1;
      if (owner_q == owner_d) begin
        hold_d = (hold_q >= MaxHold) ? MaxHold : hold_q + 8'd1;
      end else begin
        hold_d = 8'd1;
      end
    end else begin
      owner_d = OwnNone;
      hold_d  = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q   <= OwnNone;
      last_q    <= 1'b1;
      hold_q    <= 8'd0;
      rd_pend_q <= 1'b0;
      rd_id_q   <= 1'b0;
      rd_oor_q  <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
      rd_oor_q  <= rd_oor_d;
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Self-checking bench for onchip_mem_arbiter: RAM model, scoreboard of expected read returns
// per master, and directed scenarios for arbitration, routing, range and protocol handling.
module tb_onchip_mem_arbiter;

  localparam int unsigned ADDR_W    = 18;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BE_W      = 4;
  localparam int unsigned NUM_WORDS = 256000;
  localparam int unsigned MAX_HOLD  = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] m0_address, m1_address;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic              m0_proto_err, m1_proto_err;
  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [DATA_W-1:0] mem_writedata, mem_readdata;

  onchip_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .NUM_WORDS(NUM_WORDS), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid), .m0_proto_err(m0_proto_err),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid), .m1_proto_err(m1_proto_err),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int proto_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pat(input int a);
    return (32'(a) * 32'h0101_0101) ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // RAM model with 1-cycle read latency; junk on the data bus when not reading.
  bit          ram_loaded;
  logic [31:0] ram [NUM_WORDS];
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < int'(NUM_WORDS); i++) ram[i] <= pat(i);
      ram_loaded <= 1'b1;
    end else if (mem_chipselect && mem_write) begin
      ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
    end
    if (mem_chipselect && !mem_write) mem_readdata <= ram[mem_address];
    else                              mem_readdata <= 32'hDEAD_BEEF;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference memory seen from the master side, and the scoreboard of expected returns.
  typedef struct {logic [31:0] data; int cyc;} exp_t;
  logic [31:0] ref_mem [int];
  exp_t        sb [2][$];

  function automatic logic [31:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(a);
  endfunction

  function automatic logic in_rng(input logic [ADDR_W-1:0] a);
    return int'(a) < int'(NUM_WORDS);
  endfunction

  task automatic mon_rsp(input int k, input logic rdv, input logic [31:0] rdata);
    exp_t e;
    if (rdv) begin
      if (sb[k].size() == 0) begin
        check($sformatf("rdv_unexpected_m%0d", k), 1'b1, 1'b0);
      end else begin
        e = sb[k].pop_front();
        check($sformatf("rdata_m%0d", k), rdata, e.data);
        check($sformatf("rdv_latency_m%0d", k), cyc, e.cyc);
      end
    end else begin
      check($sformatf("rdata_idle_zero_m%0d", k), rdata, 32'h0);
      if (sb[k].size() > 0 && sb[k][0].cyc <= cyc) begin
        check($sformatf("rdv_missing_m%0d", k), 1'b0, 1'b1);
        void'(sb[k].pop_front());
      end
    end
  endtask

  task automatic mon_cmd(input int k, input logic acc, input logic rd, input logic wr,
                         input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input logic perr);
    exp_t e;
    check($sformatf("proto_err_m%0d", k), perr, acc && rd && wr);
    if (acc) begin
      if (wr) begin
        if (in_rng(a)) ref_mem[int'(a)] = merge(ref_rd(int'(a)), wd, be);
      end else begin
        e.data = in_rng(a) ? ref_rd(int'(a)) : 32'h0;
        e.cyc  = cyc + 1;
        sb[k].push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    logic acc0, acc1, exp_cs, exp_wr;
    if (!reset_n) begin
      sb[0].delete();
      sb[1].delete();
      check("rst_wait_m0", m0_waitrequest, 1'b1);
      check("rst_wait_m1", m1_waitrequest, 1'b1);
      check("rst_rdv", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
      check("rst_proto", {m0_proto_err, m1_proto_err}, 2'b00);
      check("rst_mem_ctl", {mem_chipselect, mem_write, mem_clken}, 3'b000);
    end else begin
      acc0 = (m0_read || m0_write) && !m0_waitrequest;
      acc1 = (m1_read || m1_write) && !m1_waitrequest;
      if (m0_proto_err) proto_cnt++;
      mon_rsp(0, m0_readdatavalid, m0_readdata);
      mon_rsp(1, m1_readdatavalid, m1_readdata);
      mon_cmd(0, acc0, m0_read, m0_write, m0_address, m0_writedata, m0_byteenable, m0_proto_err);
      mon_cmd(1, acc1, m1_read, m1_write, m1_address, m1_writedata, m1_byteenable, m1_proto_err);
      check("one_grant", acc0 && acc1, 1'b0);
      exp_cs = (acc0 && in_rng(m0_address)) || (acc1 && in_rng(m1_address));
      exp_wr = acc0 ? (in_rng(m0_address) && m0_write) : (acc1 && in_rng(m1_address) && m1_write);
      check("mem_cs", mem_chipselect, exp_cs);
      check("mem_wr", mem_write, exp_wr);
      check("mem_clken", mem_clken, 1'b1);
      if (exp_cs) check("mem_addr", mem_address, acc0 ? m0_address : m1_address);
      if (exp_wr) begin
        check("mem_wdata", mem_writedata, acc0 ? m0_writedata : m1_writedata);
        check("mem_be", mem_byteenable, acc0 ? m0_byteenable : m1_byteenable);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  task automatic drive(input int k, input logic rd, input logic wr, input int a,
                       input logic [31:0] d);
    if (k == 0) begin
      m0_read = rd; m0_write = wr; m0_address = ADDR_W'(a); m0_writedata = d; m0_byteenable = '1;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = ADDR_W'(a); m1_writedata = d; m1_byteenable = '1;
    end
  endtask

  task automatic do_reset();
    idle_all();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_state_wait", {m0_waitrequest, m1_waitrequest}, 2'b11);
    check("rst_state_clken", mem_clken, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int a0, a1;
    logic g0, g1, exp0;
    m0_address = '0; m1_address = '0; m0_byteenable = '1; m1_byteenable = '1;
    m0_writedata = '0; m1_writedata = '0;
    idle_all();
    reset_n = 1'b0;
    do_reset();
    check("post_rst_clken", mem_clken, 1'b1);

    // Single master write then read-back.
    drive(0, 0, 1, 'h10, 32'hA5A5_0001);
    #1 check("single_wr_wait", m0_waitrequest, 1'b0);
    step();
    drive(0, 1, 0, 'h10, 32'h0);
    #1 check("single_rd_wait", m0_waitrequest, 1'b0);
    step();
    idle_all();
    #1;
    check("single_rdv", m0_readdatavalid, 1'b1);
    check("single_rdata", m0_readdata, 32'hA5A5_0001);
    check("single_m1_quiet", {m1_readdatavalid, m1_readdata}, 33'h0);
    step();

    // Contention from reset: 16-grant bursts alternating between the masters.
    do_reset();
    a0 = 'h100; a1 = 'h200;
    for (int k = 0; k < 64; k++) begin
      drive(0, 1, 0, a0, 32'h0);
      drive(1, 1, 0, a1, 32'h0);
      #1;
      g0 = !m0_waitrequest; g1 = !m1_waitrequest;
      exp0 = ((k / 16) % 2) == 0;
      check("arb_m0", g0, exp0);
      check("arb_m1", g1, !exp0);
      step();
      if (g0) a0++;
      if (g1) a1++;
    end
    idle_all();
    step(); step();

    // Alternating single requests never stall.
    for (int k = 0; k < 20; k++) begin
      idle_all();
      if (k % 2 == 0) drive(0, 1, 0, 'h300 + k, 32'h0);
      else            drive(1, 1, 0, 'h400 + k, 32'h0);
      #1 check("alt_no_stall", (k % 2 == 0) ? m0_waitrequest : m1_waitrequest, 1'b0);
      step();
    end
    idle_all();
    step(); step();

    // Out-of-range accesses, then the last valid word.
    drive(1, 0, 1, 256000, 32'hFFFF_FFFF);
    #1 check("oor_wr_wait", m1_waitrequest, 1'b0);
    check("oor_wr_cs", mem_chipselect, 1'b0);
    step();
    drive(1, 1, 0, 256000, 32'h0);
    #1 check("oor_rd_cs", mem_chipselect, 1'b0);
    step();
    idle_all();
    #1 check("oor_rdv", {m1_readdatavalid, m1_readdata}, {1'b1, 32'h0});
    step();
    drive(1, 0, 1, 255999, 32'h5555_AAAA);
    #1 check("edge_wr_cs", mem_chipselect, 1'b1);
    step();
    drive(1, 1, 0, 255999, 32'h0);
    step();
    idle_all();
    #1 check("edge_rdata", m1_readdata, 32'h5555_AAAA);
    step();

    // Read and write together: executed as a write with one proto_err pulse.
    proto_cnt = 0;
    drive(0, 1, 1, 5, 32'h0000_1234);
    #1 check("proto_pulse", m0_proto_err, 1'b1);
    step();
    idle_all();
    #1 check("proto_no_rdv", m0_readdatavalid, 1'b0);
    step();
    drive(0, 1, 0, 5, 32'h0);
    step();
    idle_all();
    #1 check("proto_wr_landed", m0_readdata, 32'h0000_1234);
    step();
    check("proto_count", proto_cnt, 1);

    // Reset in the cycle after a granted m1 read cancels the return.
    drive(1, 1, 0, 7, 32'h0);
    #1 check("rstmid_grant", m1_waitrequest, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    idle_all();
    #1 check("rstmid_no_rdv", m1_readdatavalid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("rstmid_after_rdv", m1_readdatavalid, 1'b0);
    drive(0, 1, 0, 8, 32'h0);
    drive(1, 1, 0, 9, 32'h0);
    #1 check("rstmid_tie", {m0_waitrequest, m1_waitrequest}, 2'b01);
    step();
    idle_all();
    step(); step();

    check("sb_empty_m0", sb[0].size(), 0);
    check("sb_empty_m1", sb[1].size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Shares the single-port 32-bit on-chip RAM between two Avalon-MM requesters.
- m0 is the SS-OCT A-line acquisition writer. m1 is the host/Nios data path.
- Performs round-robin arbitration with a bounded hold, plus out-of-range address protection.
- Routes the 1-cycle read data back to the requester that issued the read.

Parameters:
- ADDR_W, 18, word address width of RAM and requesters.
- DATA_W, 32, data width.
- BE_W, 4, byteenable width (DATA_W/8).
- NUM_WORDS, 256000, valid RAM depth; addresses >= NUM_WORDS are out of range.
- MAX_HOLD, 16, max consecutive grants to one master while the other is requesting (range 1..255).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- mK_address  in  ADDR_W  word address (K = 0, 1, here and below).
- mK_byteenable  in  BE_W  byte lanes for writes.
- mK_read  in  1  read request.
- mK_write  in  1  write request.
- mK_writedata  in  DATA_W  write data.
- mK_waitrequest  out  1  high = command not accepted this cycle.
- mK_readdata  out  DATA_W  read data.
- mK_readdatavalid  out  1  read data valid.
- mK_proto_err  out  1  1-cycle pulse: read and write asserted together.
- mem_address  out  ADDR_W  to RAM.
- mem_byteenable  out  BE_W  to RAM.
- mem_chipselect  out  1  to RAM.
- mem_write  out  1  to RAM.
- mem_writedata  out  DATA_W  to RAM.
- mem_clken  out  1  to RAM; constant 1 out of reset, 0 in reset.
- mem_readdata  in  DATA_W  RAM output; valid the cycle after the read command.

Behaviour:
- Request: reqK = mK_read | mK_write.
- Both read and write high on one master:
  - Treated as a write; the read is ignored.
  - mK_proto_err pulses the cycle the command is accepted.
- State: owner register ∈ {NONE, M0, M1}, last register ∈ {M0, M1}, hold_cnt of 8 bits.
- Reset values: owner = NONE, last = M1 (so m0 wins the first tie), hold_cnt = 0. All readdatavalid, proto_err and mem_* control outputs are 0. mK_waitrequest = 1 while reset_n is low.
- Grant is combinational in cycle t:
  - Only one requester: it is granted.
  - Both requesting, owner = Mx still requesting and hold_cnt < MAX_HOLD: Mx is granted.
  - Otherwise (both requesting): the master other than last is granted.
  - No requester: no grant.
- Granted master in cycle t:
  - mK_waitrequest = 0.
  - The command is driven on mem_* in cycle t.
  - mem_chipselect = 1 and mem_write = write.
- Ungranted requester: mK_waitrequest = 1, and it must hold its command stable.
- Idle master: mK_waitrequest = 0 (Avalon: don't-care).
- Registered updates at the end of cycle t:
  - Granted Mx: owner <= Mx, last <= Mx.
  - hold_cnt <= hold_cnt + 1 if Mx was already the owner, else 1. Saturates at MAX_HOLD.
  - No grant: owner <= NONE, hold_cnt <= 0.
- Read return:
  - A granted read in cycle t sets a registered rd_pend and rd_id.
  - In t+1, m[rd_id]_readdatavalid = 1 and m[rd_id]_readdata = mem_readdata.
  - The other master's readdata is 0.
  - Back-to-back reads, including alternating masters, sustain 1 read per cycle.
- Out-of-range (address >= NUM_WORDS):
  - The command is accepted normally (waitrequest low, counts toward hold).
  - mem_chipselect = 0 and mem_write = 0, so a write is dropped.
  - A read returns readdatavalid in t+1 with readdata = 0.
- Write followed by read of the same address in the next cycle returns the new data (RAM semantics, no bypass).
- Reset asserted mid-operation: any pending readdatavalid is cancelled and none is issued after reset_n rises. The arbiter restarts at its reset state.

Test Plan:
- Single master: m0 writes 0xA5A5_0001 to 0x00010 at t, reads it at t+1. m0_waitrequest is 0 both cycles; m0_readdatavalid = 1 at t+2 with 0xA5A5_0001. m1 outputs stay 0.
- Contention from reset: m0 and m1 continuously issue reads. Grants are m0 x16, m1 x16, m0 x16, ... Each readdatavalid lands exactly 1 cycle after its grant with correct data. Neither master waits more than 16 consecutive cycles.
- Alternating requests: m0 requests only on even cycles, m1 only on odd. Zero waitrequest stalls occur; each read's data is returned only to its issuer.
- Out-of-range: m1 writes 0xFFFF_FFFF to 256000, then reads 256000. mem_chipselect stays 0; the read returns 0 with m1_readdatavalid. Address 255999 behaves normally.
- Protocol error: m0 asserts read and write together to address 5 with data 0x1234. The write occurs and m0_proto_err pulses once. No m0_readdatavalid is produced.
- Reset mid-read: reset_n falls in the cycle after a granted m1 read. m1_readdatavalid never asserts. After release, owner = NONE and the first tie goes to m0.
